// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store unit.
// Used by lsu_lane_align and load_store_unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // The access size is the low two bits of funct3 for every legal encoding.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [2:0] F3_B       = 3'b000;
  localparam logic [2:0] F3_H       = 3'b001;
  localparam logic [2:0] F3_W       = 3'b010;
  localparam logic [2:0] F3_D       = 3'b011;
  localparam logic [2:0] F3_BU      = 3'b100;
  localparam logic [2:0] F3_HU      = 3'b101;
  localparam logic [2:0] F3_WU      = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_BU = 3'b001;
  localparam logic [2:0] SEL_H  = 3'b010;
  localparam logic [2:0] SEL_HU = 3'b011;
  localparam logic [2:0] SEL_W  = 3'b100;
  localparam logic [2:0] SEL_WU = 3'b101;
  localparam logic [2:0] SEL_D  = 3'b110;

  function automatic logic [2:0] funct3_to_sel(input logic [2:0] funct3);
    logic [2:0] sel;
    unique case (funct3)
      F3_B:    sel = SEL_B;
      F3_H:    sel = SEL_H;
      F3_W:    sel = SEL_W;
      F3_D:    sel = SEL_D;
      F3_BU:   sel = SEL_BU;
      F3_HU:   sel = SEL_HU;
      F3_WU:   sel = SEL_WU;
      default: sel = SEL_B;
    endcase
    return sel;
  endfunction

  function automatic lsu_size_e funct3_to_size(input logic [2:0] funct3);
    return lsu_size_e'(funct3[1:0]);
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
    logic bad;
    unique case (size)
      SZ_B: bad = 1'b0;
      SZ_H: bad = off[0];
      SZ_W: bad = |off[1:0];
      SZ_D: bad = |off;
    endcase
    return bad;
  endfunction

  // Clears the offset bits that fall below the access size.
  function automatic logic [2:0] align_offset(input lsu_size_e size, input logic [2:0] off);
    logic [2:0] aligned;
    unique case (size)
      SZ_B: aligned = off;
      SZ_H: aligned = {off[2:1], 1'b0};
      SZ_W: aligned = {off[2], 2'b00};
      SZ_D: aligned = 3'b000;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: byte offset and access size to write strobes,
// write data shifted up into its lanes, read data shifted down to bit 0.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  lsu_size_e   size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_shifted,
  output logic [63:0] rdata_shifted
);

  logic [5:0] bit_shift;

  assign bit_shift = {offset, 3'b000};

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    wstrb = 8'h00;
    unique case (size)
      SZ_B: wstrb = 8'h01 << offset;
      SZ_H: wstrb = 8'h03 << offset;
      SZ_W: wstrb = 8'h0F << offset;
      SZ_D: wstrb = 8'hFF;
    endcase
  end

  assign wdata_shifted = wdata << bit_shift;
  assign rdata_shifted = rdata >> bit_shift;

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per handshake, IDLE -> ACCESS -> RESP -> IDLE.
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned requests instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        load_valid,
  output logic [63:0] mem_value,
  output logic [2:0]  sel_mem_extension,
  output logic        store_done,
  output logic        access_error
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  lsu_state_e       state, state_next;

  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  lsu_size_e        size_q;
  logic             store_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             store_done_q;
  logic [63:0]      mem_value_q;

  lsu_size_e        req_size;
  logic [2:0]       req_off;
  logic [2:0]       req_off_eff;
  logic             req_bad;
  logic             accept;
  logic             timeout_hit;

  logic [7:0]       lane_wstrb;
  logic [63:0]      lane_wdata;
  logic [63:0]      lane_rdata;

  assign req_size = funct3_to_size(req_funct3);
  assign req_off  = req_addr[2:0];

`ifdef MISALIGN_TRAP_EN
  assign req_bad     = (req_funct3 == F3_ILLEGAL) || is_misaligned(req_size, req_off);
  assign req_off_eff = req_off;
`else
  assign req_bad     = (req_funct3 == F3_ILLEGAL);
  assign req_off_eff = align_offset(req_size, req_off);
`endif

  assign accept = (state == IDLE) && req_valid;

  // An ack in the final allowed cycle still wins over the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (state == ACCESS) && !mem_ack &&
                       (cnt_q == CNT_LAST) && !reset;

  lsu_lane_align u_lane_align (
    .offset        (addr_q[2:0]),
    .size          (size_q),
    .wdata         (wdata_q),
    .rdata         (mem_rdata),
    .wstrb         (lane_wstrb),
    .wdata_shifted (lane_wdata),
    .rdata_shifted (lane_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    load_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad) state_next = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack)          state_next = store_q ? IDLE : RESP;
        else if (timeout_hit) state_next = IDLE;
      end
      RESP: begin
        load_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_B;
      store_q      <= 1'b0;
      sel_q        <= SEL_B;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      store_done_q <= 1'b0;
      mem_value_q  <= '0;
    end else begin
      err_q        <= 1'b0;
      store_done_q <= 1'b0;

      if (accept) begin
        err_q <= req_bad;
        if (!req_bad) begin
          addr_q  <= {req_addr[63:3], req_off_eff};
          wdata_q <= req_wdata;
          size_q  <= req_size;
          store_q <= req_store;
          sel_q   <= funct3_to_sel(req_funct3);
        end
      end

      if (state == ACCESS && mem_ack) begin
        if (store_q) store_done_q <= 1'b1;
        else         mem_value_q  <= lane_rdata;
      end

      if (state == ACCESS && state_next == ACCESS) cnt_q <= cnt_q + 1'b1;
      else                                         cnt_q <= '0;
    end
  end

  assign mem_addr          = {addr_q[63:3], 3'b000};
  assign mem_we            = mem_req & store_q;
  assign mem_wdata         = lane_wdata;
  assign mem_wstrb         = mem_we ? lane_wstrb : 8'h00;
  assign mem_value         = mem_value_q;
  assign sel_mem_extension = sel_q;
  assign store_done        = store_done_q;
  assign access_error      = err_q | timeout_hit;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, timeout, reset abort and
// randomized accesses checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        load_valid;
  logic [63:0] mem_value;
  logic [2:0]  sel_mem_extension;
  logic        store_done;
  logic        access_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_store         (req_store),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .load_valid        (load_valid),
    .mem_value         (mem_value),
    .sel_mem_extension (sel_mem_extension),
    .store_done        (store_done),
    .access_error      (access_error)
  );

  // Reference model: access width in bytes, legality, effective byte offset, extension select.
  function automatic int exp_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic exp_bad(input logic [2:0] f3, input logic [63:0] a);
    int o;
    o = int'(a[2:0]);
    if (f3 == 3'b111) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    return (o % exp_bytes(f3)) != 0;
`else
    return (o < 0);
`endif
  endfunction

  function automatic int exp_off(input logic [2:0] f3, input logic [63:0] a);
    int b;
    int o;
    b = exp_bytes(f3);
    o = int'(a[2:0]);
    return (o / b) * b;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [2:0] f3, input logic [63:0] a);
    int mask;
    mask = ((1 << exp_bytes(f3)) - 1) << exp_off(f3, a);
    return mask[7:0];
  endfunction

  function automatic logic [2:0] exp_sel(input logic [2:0] f3);
    logic [2:0] tab [8];
    tab = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b000};
    return tab[f3];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access; the ack arrives in ACCESS cycle wait_cyc+1.
  task automatic do_access(input string name, input logic st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input int wait_cyc);
    int          o;
    logic [63:0] ev;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick;
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    if (exp_bad(f3, a)) begin
      checks++;
      if (access_error !== 1'b1) begin
        errors++; $display("FAIL %s error_pulse: got %b want 1", name, access_error);
      end
      checks++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL %s error_no_access: mem_req=%b req_ready=%b want 0/1", name, mem_req, req_ready);
      end
      tick;
      checks++;
      if (access_error !== 1'b0) begin
        errors++; $display("FAIL %s error_one_cycle: got %b want 0", name, access_error);
      end
      return;
    end
    o = exp_off(f3, a);
    for (int i = 0; i <= wait_cyc; i++) begin
      if (i == wait_cyc) begin mem_ack = 1'b1; mem_rdata = rd; end
      else               mem_rdata = {$urandom, $urandom};
      #1;
      checks++;
      if (mem_req !== 1'b1 || req_ready !== 1'b0 || access_error !== 1'b0) begin
        errors++; $display("FAIL %s access_ctl: mem_req=%b req_ready=%b err=%b want 1/0/0", name, mem_req, req_ready, access_error);
      end
      checks++;
      if (mem_addr !== {a[63:3], 3'b000} || mem_we !== st) begin
        errors++; $display("FAIL %s addr_we: got %h/%b want %h/%b", name, mem_addr, mem_we, {a[63:3], 3'b000}, st);
      end
      checks++;
      if (mem_wstrb !== (st ? exp_strb(f3, a) : 8'h00)) begin
        errors++; $display("FAIL %s wstrb: got %h want %h", name, mem_wstrb, st ? exp_strb(f3, a) : 8'h00);
      end
      if (st) begin
        ev = wd << (8 * o);
        checks++;
        if (mem_wdata !== ev) begin
          errors++; $display("FAIL %s wdata: got %h want %h", name, mem_wdata, ev);
        end
      end
      tick;
    end
    mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
    if (st) begin
      checks++;
      if (store_done !== 1'b1 || mem_req !== 1'b0 || req_ready !== 1'b1 || load_valid !== 1'b0) begin
        errors++; $display("FAIL %s store_done: done=%b mem_req=%b ready=%b lv=%b want 1/0/1/0", name, store_done, mem_req, req_ready, load_valid);
      end
      tick;
      checks++;
      if (store_done !== 1'b0) begin
        errors++; $display("FAIL %s store_done_pulse: got %b want 0", name, store_done);
      end
    end else begin
      ev = rd >> (8 * o);
      checks++;
      if (load_valid !== 1'b1 || mem_req !== 1'b0 || req_ready !== 1'b0 || store_done !== 1'b0) begin
        errors++; $display("FAIL %s load_valid: lv=%b mem_req=%b ready=%b done=%b want 1/0/0/0", name, load_valid, mem_req, req_ready, store_done);
      end
      checks++;
      if (mem_value !== ev || sel_mem_extension !== exp_sel(f3)) begin
        errors++; $display("FAIL %s load_data: got %h sel %b want %h sel %b", name, mem_value, sel_mem_extension, ev, exp_sel(f3));
      end
      tick;
      checks++;
      if (load_valid !== 1'b0 || req_ready !== 1'b1 || mem_value !== ev) begin
        errors++; $display("FAIL %s load_hold: lv=%b ready=%b value=%h want 0/1/%h", name, load_valid, req_ready, mem_value, ev);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin
      errors++; $display("FAIL reset_ctl: ready=%b mem_req=%b we=%b strb=%h want 1/0/0/00", req_ready, mem_req, mem_we, mem_wstrb);
    end
    checks++;
    if (load_valid !== 1'b0 || store_done !== 1'b0 || access_error !== 1'b0 ||
        mem_value !== 64'h0 || sel_mem_extension !== 3'b000 || mem_addr !== 64'h0) begin
      errors++; $display("FAIL reset_out: lv=%b done=%b err=%b value=%h sel=%b addr=%h want all 0", load_valid, store_done, access_error, mem_value, sel_mem_extension, mem_addr);
    end
  endtask

  task automatic test_directed;
    do_access("lb_1003", 1'b0, 3'b000, 64'h1003, 64'h0, 64'h8877665544332211, 0);
    checks++;
    if (mem_value[7:0] !== 8'h44 || sel_mem_extension !== 3'b000) begin
      errors++; $display("FAIL lb_byte: got %h sel %b want 44 sel 000", mem_value[7:0], sel_mem_extension);
    end
    do_access("sd_2000", 1'b1, 3'b011, 64'h2000, 64'hDEADBEEF00000001, 64'h0, 1);
    do_access("sh_2006", 1'b1, 3'b001, 64'h2006, 64'h000000000000ABCD, 64'h0, 0);
    do_access("lw_1002", 1'b0, 3'b010, 64'h1002, 64'h0, 64'h1122334455667788, 2);
    do_access("illegal", 1'b0, 3'b111, 64'h1000, 64'h0, 64'h0, 0);
    do_access("lhu_last", 1'b0, 3'b101, 64'h3004, 64'h0, 64'hFEDCBA9876543210, TO - 1);
  endtask

  task automatic test_timeout;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h4000;
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      checks++;
      if (mem_req !== 1'b1 || access_error !== (c == TO)) begin
        errors++; $display("FAIL timeout_cycle%0d: mem_req=%b err=%b want 1/%b", c, mem_req, access_error, c == TO);
      end
      tick;
    end
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || access_error !== 1'b0 || load_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: ready=%b mem_req=%b err=%b lv=%b want 1/0/0/0", req_ready, mem_req, access_error, load_valid);
    end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b0 || store_done !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL late_ack: lv=%b done=%b mem_req=%b ready=%b want 0/0/0/1", load_valid, store_done, mem_req, req_ready);
    end
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h5000; req_wdata = 64'h55;
    tick;
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: mem_req=%b want 1", mem_req);
    end
    reset = 1'b1; mem_ack = 1'b1;
    tick;
    reset = 1'b0; mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || store_done !== 1'b0 ||
        access_error !== 1'b0 || load_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: mem_req=%b ready=%b done=%b err=%b lv=%b want 0/1/0/0/0", mem_req, req_ready, store_done, access_error, load_valid);
    end
    tick;
    checks++;
    if (store_done !== 1'b0 || access_error !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: done=%b err=%b mem_req=%b want 0/0/0", store_done, access_error, mem_req);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd;
    rd = 64'h0102030405060708;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b100; req_addr = 64'h1005;
    tick;
    req_funct3 = 3'b011; req_addr = 64'h3000;
    checks++;
    if (req_ready !== 1'b0 || mem_addr !== 64'h1000) begin
      errors++; $display("FAIL b2b_busy: ready=%b addr=%h want 0/1000", req_ready, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b1 || mem_value !== (rd >> 40) || sel_mem_extension !== 3'b001) begin
      errors++; $display("FAIL b2b_first: lv=%b value=%h sel=%b want 1/%h/001", load_valid, mem_value, sel_mem_extension, rd >> 40);
    end
    tick;
    tick;
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h3000 || sel_mem_extension !== 3'b110) begin
      errors++; $display("FAIL b2b_second: mem_req=%b addr=%h sel=%b want 1/3000/110", mem_req, mem_addr, sel_mem_extension);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (load_valid !== 1'b1 || mem_value !== rd) begin
      errors++; $display("FAIL b2b_second_data: lv=%b value=%h want 1/%h", load_valid, mem_value, rd);
    end
    tick;
  endtask

  task automatic test_random;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] a;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      a  = {$urandom, $urandom};
      do_access("random", st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, TO - 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset;
    test_directed;
    test_timeout;
    test_reset_mid_access;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
